// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// One word read at a time: req/addr are held until ack returns rdata.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads on the imem bus,
// buffers one returned word and drives the IF/ID register for decode.
// Optional feature macro: IF_ALIGN_CHECK_EN (misaligned fetch raises fetch_exc_o
// and halts fetching; when undefined the fetch address is forced word-aligned).
//
// state | meaning
// IDLE  | reset just released, no request yet
// REQ   | request outstanding on imem, buffer empty
// FULL  | one word buffered, no request issued
// HALT  | misaligned fetch seen, fetching stopped until reset
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        next_inst_in_delayslot_i,
  if_fetch_if.master  imem,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        is_in_delayslot_o,
  output logic        fetch_stall_o,
  output logic        fetch_exc_o
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, HALT} state_e;

  state_e      state, state_nxt;
  logic [31:0] fetch_pc, fetch_addr;
  logic [31:0] buf_pc, buf_inst;
  logic [31:0] redirect_target, target_eff;
  logic        redirect_pending, dslot_pending;
  logic        req, misaligned, ack_ok, branch_accept;
  logic        redirect_eff, consume, dslot_eff, load_inst, take_exc;

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned = (fetch_pc[1:0] != 2'b00);
  assign fetch_addr = fetch_pc;
`else
  assign misaligned = 1'b0;
  assign fetch_addr = {fetch_pc[31:2], 2'b00};
`endif

  assign imem.req  = req;
  assign imem.addr = fetch_addr;

  // An ack only counts while a request is actually on the bus.
  assign ack_ok        = req & imem.ack;
  assign branch_accept = branch_flag_i & ~stall_i;
  // The delay-slot word is either buffered or being acked when fetch_pc is next
  // re-loaded; that is the point where a pending redirect is applied.
  assign consume       = ack_ok | (state == FULL);
  assign redirect_eff  = branch_accept | redirect_pending;
  assign target_eff    = redirect_pending ? redirect_target : branch_target_address_i;
  assign dslot_eff     = dslot_pending | (branch_accept & next_inst_in_delayslot_i);
  assign load_inst     = ~stall_i & ((state == FULL) | ack_ok);
  assign take_exc      = (state == REQ) & misaligned & ~stall_i;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fetch FSM next state and request strobe.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (misaligned) begin
          if (!stall_i) state_nxt = HALT;
        end else begin
          req = 1'b1;
          if (imem.ack) state_nxt = stall_i ? FULL : REQ;
        end
      end
      FULL: if (!stall_i) state_nxt = REQ;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch PC, redirect and delay-slot bookkeeping, one-entry buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc          <= RESET_PC;
      buf_pc            <= 32'h0;
      buf_inst          <= 32'h0;
      redirect_pending  <= 1'b0;
      redirect_target   <= 32'h0;
      dslot_pending     <= 1'b0;
      pc_o              <= 32'h0;
      inst_o            <= 32'h0;
      is_in_delayslot_o <= 1'b0;
      fetch_stall_o     <= 1'b0;
    end else begin
      if (consume && redirect_eff) begin
        fetch_pc         <= target_eff;
        redirect_pending <= 1'b0;
      end else begin
        if (ack_ok) fetch_pc <= fetch_pc + 32'd4;
        if (branch_accept) begin
          redirect_pending <= 1'b1;
          redirect_target  <= branch_target_address_i;
        end
      end

      if (ack_ok && stall_i) begin
        buf_pc   <= fetch_addr;
        buf_inst <= imem.rdata;
      end

      dslot_pending <= load_inst ? 1'b0 : dslot_eff;

      if (!stall_i) begin
        if (state == FULL) begin
          pc_o              <= buf_pc;
          inst_o            <= buf_inst;
          is_in_delayslot_o <= dslot_eff;
          fetch_stall_o     <= 1'b0;
        end else if (ack_ok) begin
          pc_o              <= fetch_addr;
          inst_o            <= imem.rdata;
          is_in_delayslot_o <= dslot_eff;
          fetch_stall_o     <= 1'b0;
        end else if (take_exc) begin
          pc_o              <= fetch_addr;
          inst_o            <= 32'h0;
          is_in_delayslot_o <= 1'b0;
          fetch_stall_o     <= 1'b0;
        end else begin
          inst_o            <= 32'h0;
          is_in_delayslot_o <= 1'b0;
          fetch_stall_o     <= 1'b1;
        end
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic exc_q;

  // Exception flag stays up while fetching is halted; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)           exc_q <= 1'b0;
    else if (take_exc) exc_q <= 1'b1;
  end

  assign fetch_exc_o = exc_q;
`else
  assign fetch_exc_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = 32'h0;
  logic        next_inst_in_delayslot_i = 1'b0;
  logic [31:0] pc_o, inst_o;
  logic        is_in_delayslot_o, fetch_stall_o, fetch_exc_o;

  if_fetch_if bus();

  int lat = 0;
  int wait_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ds;
  } exp_t;
  exp_t exp_q[$];

  logic        edge_stall, edge_rst, edge_ack, loaded;
  logic [31:0] edge_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  always #5 clk = ~clk;

  // Instruction memory: acks after 'lat' wait cycles, data is a function of address.
  assign bus.ack   = bus.req & (wait_cnt >= lat);
  assign bus.rdata = mem_word(bus.addr);
  always @(posedge clk) begin
    if (rst || !bus.req || bus.ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  if_fetch dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .next_inst_in_delayslot_i(next_inst_in_delayslot_i),
    .imem(bus),
    .pc_o(pc_o),
    .inst_o(inst_o),
    .is_in_delayslot_o(is_in_delayslot_o),
    .fetch_stall_o(fetch_stall_o),
    .fetch_exc_o(fetch_exc_o)
  );

  // One clock; inputs as they stand are what the edge sees. Sample 1 ns later.
  task automatic tick();
    edge_stall = stall_i;
    edge_rst   = rst;
    edge_ack   = bus.ack;
    edge_rdata = bus.rdata;
    @(posedge clk);
    #1;
    loaded = !edge_stall && !edge_rst && (fetch_stall_o === 1'b0) && (fetch_exc_o === 1'b0);
  endtask

  task automatic do_reset(input int l);
    lat = l;
    rst = 1'b1;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    next_inst_in_delayslot_i = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic ds);
    exp_t e;
    e.pc = pc;
    e.inst = mem_word(pc);
    e.ds = ds;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    lat = 3;
    rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({bus.req, bus.addr, pc_o, inst_o, is_in_delayslot_o, fetch_stall_o, fetch_exc_o} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got req=%b addr=%h pc=%h inst=%h ds=%b fs=%b exc=%b, want all 0",
               bus.req, bus.addr, pc_o, inst_o, is_in_delayslot_o, fetch_stall_o, fetch_exc_o);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cycle0_req: got %b want 0", bus.req);
    end
    tick();
    vectors++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=0", bus.req, bus.addr);
    end
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.req !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0 || fetch_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_req: got req=%b pc=%h inst=%h fs=%b want 0/0/0/0",
               bus.req, pc_o, inst_o, fetch_stall_o);
    end
    rst = 1'b0;
    exp_q.delete();
    push(32'h0, 1'b0);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      tick();
      if (loaded) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc_o !== e.pc || inst_o !== e.inst || is_in_delayslot_o !== e.ds) begin
          miscompares++;
          $display("FAIL reset_refetch: got pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                   pc_o, inst_o, is_in_delayslot_o, e.pc, e.inst, e.ds);
        end
      end
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_refetch_timeout: %0d words undelivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_zero_wait();
    exp_t e;
    bit started = 0;
    do_reset(0);
    for (int i = 0; i < 8; i++) push(32'(i * 4), 1'b0);
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      tick();
      if (edge_ack) begin
        vectors++;
        if (!loaded || inst_o !== edge_rdata) begin
          miscompares++;
          $display("FAIL zw_ack_to_ifid: got loaded=%b inst=%h want loaded=1 inst=%h",
                   loaded, inst_o, edge_rdata);
        end
      end
      if (loaded) begin
        e = exp_q.pop_front();
        started = 1;
        vectors++;
        if (pc_o !== e.pc || inst_o !== e.inst || is_in_delayslot_o !== e.ds) begin
          miscompares++;
          $display("FAIL zw_stream: got pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                   pc_o, inst_o, is_in_delayslot_o, e.pc, e.inst, e.ds);
        end
      end else if (started) begin
        vectors++;
        miscompares++;
        $display("FAIL zw_gap: got fs=%b inst=%h want a new word every cycle", fetch_stall_o, inst_o);
      end
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL zw_timeout: %0d words undelivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_wait3();
    exp_t e;
    int nloads = 0;
    int nb = 0;
    bit prev_wait = 0;
    logic [31:0] prev_addr = 32'h0;
    do_reset(3);
    push(32'h0, 1'b0);
    push(32'h4, 1'b0);
    push(32'h8, 1'b0);
    for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      tick();
      if (loaded) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc_o !== e.pc || inst_o !== e.inst || is_in_delayslot_o !== e.ds) begin
          miscompares++;
          $display("FAIL w3_word: got pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                   pc_o, inst_o, is_in_delayslot_o, e.pc, e.inst, e.ds);
        end
        if (nloads > 0) begin
          vectors++;
          if (nb !== 3) begin
            miscompares++;
            $display("FAIL w3_bubble_count: got %0d want 3", nb);
          end
        end
        nloads++;
        nb = 0;
      end else if (nloads > 0) begin
        nb++;
        vectors++;
        if (inst_o !== 32'h0 || fetch_stall_o !== 1'b1 || is_in_delayslot_o !== 1'b0) begin
          miscompares++;
          $display("FAIL w3_bubble_value: got inst=%h fs=%b ds=%b want 0/1/0",
                   inst_o, fetch_stall_o, is_in_delayslot_o);
        end
      end
      if (prev_wait) begin
        vectors++;
        if (bus.req !== 1'b1 || bus.addr !== prev_addr) begin
          miscompares++;
          $display("FAIL w3_addr_stable: got req=%b addr=%h want req=1 addr=%h", bus.req, bus.addr, prev_addr);
        end
      end
      prev_wait = bus.req && !bus.ack;
      prev_addr = bus.addr;
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL w3_timeout: %0d words undelivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    exp_t e;
    bit got4 = 0;
    do_reset(0);
    for (int i = 0; i < 5; i++) push(32'(i * 4), 1'b0);
    for (int cyc = 0; cyc < 20 && !got4; cyc++) begin
      tick();
      if (loaded) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc_o !== e.pc || inst_o !== e.inst) begin
          miscompares++;
          $display("FAIL st_pre: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst);
        end
        got4 = (pc_o === 32'h4);
      end
    end
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (pc_o !== 32'h4 || inst_o !== mem_word(32'h4) || fetch_stall_o !== 1'b0 || bus.req !== 1'b0) begin
        miscompares++;
        $display("FAIL st_hold: got pc=%h inst=%h fs=%b req=%b want pc=4 inst=%h fs=0 req=0",
                 pc_o, inst_o, fetch_stall_o, bus.req, mem_word(32'h4));
      end
    end
    stall_i = 1'b0;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      tick();
      if (loaded) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc_o !== e.pc || inst_o !== e.inst || is_in_delayslot_o !== e.ds) begin
          miscompares++;
          $display("FAIL st_post: got pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                   pc_o, inst_o, is_in_delayslot_o, e.pc, e.inst, e.ds);
        end
      end
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL st_timeout: %0d words undelivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_branch();
    exp_t e;
    int lats[3] = '{0, 2, 0};
    logic [31:0] tgts[3] = '{32'h0000_0040, 32'h0000_0040, 32'hFFFF_FFF8};
    bit seen18;
    for (int r = 0; r < 3; r++) begin
      do_reset(lats[r]);
      seen18 = 0;
      for (int i = 0; i < 5; i++) push(32'(i * 4), 1'b0);
      push(32'h14, 1'b1);
      for (int i = 0; i < 4; i++) push(tgts[r] + 32'(i * 4), 1'b0);
      for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
        tick();
        branch_flag_i = 1'b0;
        next_inst_in_delayslot_i = 1'b0;
        if (loaded) begin
          e = exp_q.pop_front();
          vectors++;
          if (pc_o !== e.pc || inst_o !== e.inst || is_in_delayslot_o !== e.ds) begin
            miscompares++;
            $display("FAIL br_seq run%0d: got pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                     r, pc_o, inst_o, is_in_delayslot_o, e.pc, e.inst, e.ds);
          end
          if (pc_o === 32'h10) begin
            branch_flag_i = 1'b1;
            branch_target_address_i = tgts[r];
            next_inst_in_delayslot_i = 1'b1;
          end
          if (pc_o === 32'h14) begin
            vectors++;
            if (bus.req !== 1'b1 || bus.addr !== tgts[r]) begin
              miscompares++;
              $display("FAIL br_next_req run%0d: got req=%b addr=%h want req=1 addr=%h",
                       r, bus.req, bus.addr, tgts[r]);
            end
          end
        end
        if (bus.req === 1'b1 && bus.addr === 32'h18) seen18 = 1;
      end
      vectors++;
      if (exp_q.size() !== 0 || seen18) begin
        miscompares++;
        $display("FAIL br_end run%0d: got left=%0d req18=%b want 0/0", r, exp_q.size(), seen18);
      end
    end
  endtask

  task automatic test_align();
    exp_t e;
    bit at14 = 0;
    do_reset(0);
    for (int i = 0; i < 5; i++) push(32'(i * 4), 1'b0);
    push(32'h14, 1'b1);
`ifndef IF_ALIGN_CHECK_EN
    push(32'h40, 1'b0);
    push(32'h44, 1'b0);
`endif
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      tick();
      branch_flag_i = 1'b0;
      next_inst_in_delayslot_i = 1'b0;
      vectors++;
      if (fetch_exc_o !== 1'b0) begin
        miscompares++;
        $display("FAIL al_exc_early: got %b want 0", fetch_exc_o);
      end
      if (loaded) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc_o !== e.pc || inst_o !== e.inst || is_in_delayslot_o !== e.ds) begin
          miscompares++;
          $display("FAIL al_seq: got pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                   pc_o, inst_o, is_in_delayslot_o, e.pc, e.inst, e.ds);
        end
        at14 = (pc_o === 32'h14);
        if (pc_o === 32'h10) begin
          branch_flag_i = 1'b1;
          branch_target_address_i = 32'h42;
          next_inst_in_delayslot_i = 1'b1;
        end
      end
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL al_timeout: %0d words undelivered, want 0", exp_q.size());
    end
`ifdef IF_ALIGN_CHECK_EN
    vectors++;
    if (!at14 || bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL al_no_req: got at14=%b req=%b want 1/0", at14, bus.req);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (fetch_exc_o !== 1'b1 || pc_o !== 32'h42 || inst_o !== 32'h0 || bus.req !== 1'b0) begin
        miscompares++;
        $display("FAIL al_exc: got exc=%b pc=%h inst=%h req=%b want 1/42/0/0",
                 fetch_exc_o, pc_o, inst_o, bus.req);
      end
    end
`else
    vectors++;
    if (at14) begin
      miscompares++;
      $display("FAIL al_forced: last word still pc=14, want aligned 0x44 delivered");
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait3();
    test_stall();
    test_branch();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
